// File: rtl/alu_pipe.sv
// alu_pipe: capture FSM pairing split operand beats, feeding a PIPE_STAGES-deep ALU result pipeline.
// Optional feature: define ALU_PIPE_SIGNED_EN to add signed S_ADD (cmd 11) and S_SUB (cmd 12).
//
// state  | meaning
// IDLE   | no operand pending
// WAIT_A | opb/cmd/mode/cin latched, waiting for opa
// WAIT_B | opa/cmd/mode/cin latched, waiting for opb
module alu_pipe #(
    parameter int WIDTH       = 8,
    parameter int CMD_WIDTH   = 4,
    parameter int PIPE_STAGES = 1,
    parameter int WAIT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic                   mode,
    input  logic                   cin,
    input  logic [1:0]             inp_valid,
    input  logic [CMD_WIDTH-1:0]   cmd,
    input  logic [WIDTH-1:0]       opa,
    input  logic [WIDTH-1:0]       opb,
    output logic [2*WIDTH-1:0]     res,
    output logic                   cout,
    output logic                   oflow,
    output logic                   g,
    output logic                   l,
    output logic                   e,
    output logic                   err,
    output logic                   res_valid
);
    localparam int SH_W = $clog2(WIDTH);
    localparam logic [WIDTH:0]     ONE_W1 = (WIDTH+1)'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

    typedef struct packed {
        logic [2*WIDTH-1:0] res;
        logic               cout;
        logic               oflow;
        logic               g;
        logic               l;
        logic               e;
        logic               err;
    } result_t;

    typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B} state_t;

    state_t               state, state_nxt;
    logic [7:0]           timer;
    logic [WIDTH-1:0]     lat_a, lat_b;
    logic [CMD_WIDTH-1:0] lat_cmd;
    logic                 lat_mode, lat_cin;

    logic                 issue, force_err, timeout;
    logic                 latch_a, latch_b, timer_clr, timer_inc;
    logic [1:0]           need;
    logic [WIDTH-1:0]     ex_a, ex_b;
    logic [CMD_WIDTH-1:0] ex_cmd;
    logic                 ex_mode, ex_cin;
    result_t              issue_res;

    result_t              pipe_q [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] pipe_v;

    // {need_b, need_a}
    function automatic logic [1:0] op_need(input logic m, input logic [CMD_WIDTH-1:0] c);
        int ci;
        ci = int'(c);
        op_need = 2'b11;
        if (m) begin
            if (ci == 4 || ci == 5)      op_need = 2'b01;
            else if (ci == 6 || ci == 7) op_need = 2'b10;
        end else begin
            if (ci == 6 || ci == 8 || ci == 9)       op_need = 2'b01;
            else if (ci == 7 || ci == 10 || ci == 11) op_need = 2'b10;
        end
    endfunction

    function automatic result_t alu_compute(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic [CMD_WIDTH-1:0] c, input logic m,
                                            input logic cy);
        result_t            r;
        logic [WIDTH:0]     sum;
        logic [2*WIDTH-1:0] pa, pb, prod;
        logic [WIDTH-1:0]   lg;
        logic [SH_W-1:0]    amt;
        int                 ci;
        r    = '0;
        sum  = '0;
        pa   = '0;
        pb   = '0;
        prod = '0;
        lg   = '0;
        amt  = b[SH_W-1:0];
        ci   = int'(c);
        if (m) begin
            case (ci)
                0: sum = {1'b0, a} + {1'b0, b};
                1: sum = {1'b0, a} - {1'b0, b};
                2: sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cy};
                3: sum = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cy};
                4: sum = {1'b0, a} + ONE_W1;
                5: sum = {1'b0, a} - ONE_W1;
                6: sum = {1'b0, b} + ONE_W1;
                7: sum = {1'b0, b} - ONE_W1;
                default: sum = '0;
            endcase
            case (ci)
                0, 2, 4, 6: begin
                    r.res  = {{(WIDTH-1){1'b0}}, sum};
                    r.cout = sum[WIDTH];
                end
                1, 3, 5, 7: begin
                    r.res   = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
                    r.oflow = sum[WIDTH];
                end
                8: begin
                    r.e = (a == b);
                    r.g = (a > b);
                    r.l = (a < b);
                end
                9: begin
                    pa    = {{WIDTH{1'b0}}, a} + ONE_2W;
                    pb    = {{WIDTH{1'b0}}, b} + ONE_2W;
                    prod  = pa * pb;
                    r.res = prod;
                end
                10: begin
                    pa    = {{WIDTH{1'b0}}, a} << 1;
                    pb    = {{WIDTH{1'b0}}, b};
                    prod  = pa * pb;
                    r.res = prod;
                end
`ifdef ALU_PIPE_SIGNED_EN
                11: begin
                    lg      = a + b;
                    r.oflow = (a[WIDTH-1] == b[WIDTH-1]) && (lg[WIDTH-1] != a[WIDTH-1]);
                    r.res   = {{WIDTH{lg[WIDTH-1]}}, lg};
                end
                12: begin
                    lg      = a - b;
                    r.oflow = (a[WIDTH-1] != b[WIDTH-1]) && (lg[WIDTH-1] != a[WIDTH-1]);
                    r.res   = {{WIDTH{lg[WIDTH-1]}}, lg};
                    r.e     = (a == b);
                    r.g     = ($signed(a) > $signed(b));
                    r.l     = ($signed(a) < $signed(b));
                end
`endif
                default: r.err = 1'b1;
            endcase
        end else begin
            case (ci)
                0:  lg = a & b;
                1:  lg = ~(a & b);
                2:  lg = a | b;
                3:  lg = ~(a | b);
                4:  lg = a ^ b;
                5:  lg = ~(a ^ b);
                6:  lg = ~a;
                7:  lg = ~b;
                8:  lg = a >> 1;
                9:  lg = a << 1;
                10: lg = b >> 1;
                11: lg = b << 1;
                12: begin
                    prod  = {a, a} << amt;
                    lg    = prod[2*WIDTH-1:WIDTH];
                    r.err = |(b >> SH_W);
                end
                13: begin
                    prod  = {a, a} >> amt;
                    lg    = prod[WIDTH-1:0];
                    r.err = |(b >> SH_W);
                end
                default: r.err = 1'b1;
            endcase
            r.res = {{WIDTH{1'b0}}, lg};
        end
        return r;
    endfunction

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        force_err = 1'b0;
        timeout   = 1'b0;
        latch_a   = 1'b0;
        latch_b   = 1'b0;
        timer_clr = 1'b0;
        timer_inc = 1'b0;
        ex_a      = opa;
        ex_b      = opb;
        ex_cmd    = cmd;
        ex_mode   = mode;
        ex_cin    = cin;
        need      = op_need(mode, cmd);
        case (state)
            IDLE: begin
                timer_clr = 1'b1;
                if (inp_valid == 2'b11) begin
                    issue = 1'b1;
                end else if (inp_valid != 2'b00) begin
                    if (need == 2'b11) begin
                        if (inp_valid[0]) begin
                            latch_a   = 1'b1;
                            state_nxt = WAIT_B;
                        end else begin
                            latch_b   = 1'b1;
                            state_nxt = WAIT_A;
                        end
                    end else begin
                        issue     = 1'b1;
                        force_err = ((need & inp_valid) != need);
                    end
                end
            end
            WAIT_A, WAIT_B: begin
                ex_cmd  = lat_cmd;
                ex_mode = lat_mode;
                ex_cin  = lat_cin;
                if (state == WAIT_A) ex_b = lat_b;
                else                 ex_a = lat_a;
                // A late operand arriving on the timeout cycle still wins.
                if ((state == WAIT_A && inp_valid[0]) || (state == WAIT_B && inp_valid[1])) begin
                    issue     = 1'b1;
                    state_nxt = IDLE;
                end else if (timer == 8'(WAIT_CYCLES)) begin
                    issue     = 1'b1;
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        issue_res = alu_compute(ex_a, ex_b, ex_cmd, ex_mode, ex_cin);
        if (timeout) begin
            issue_res     = '0;
            issue_res.err = 1'b1;
        end else if (force_err) begin
            issue_res.err = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            lat_a    <= '0;
            lat_b    <= '0;
            lat_cmd  <= '0;
            lat_mode <= 1'b0;
            lat_cin  <= 1'b0;
        end else if (ce) begin
            state <= state_nxt;
            if (timer_clr)      timer <= '0;
            else if (timer_inc) timer <= timer + 8'd1;
            if (latch_a) lat_a <= opa;
            if (latch_b) lat_b <= opb;
            if (latch_a || latch_b) begin
                lat_cmd  <= cmd;
                lat_mode <= mode;
                lat_cin  <= cin;
            end
        end
    end

    // Stage data only moves with a valid token so the last stage holds between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) pipe_q[i] <= '0;
        end else if (ce) begin
            pipe_v[0] <= issue;
            if (issue) pipe_q[0] <= issue_res;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                if (pipe_v[i-1]) pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign res       = pipe_q[PIPE_STAGES-1].res;
    assign cout      = pipe_q[PIPE_STAGES-1].cout;
    assign oflow     = pipe_q[PIPE_STAGES-1].oflow;
    assign g         = pipe_q[PIPE_STAGES-1].g;
    assign l         = pipe_q[PIPE_STAGES-1].l;
    assign e         = pipe_q[PIPE_STAGES-1].e;
    assign err       = pipe_q[PIPE_STAGES-1].err;
    assign res_valid = pipe_v[PIPE_STAGES-1];

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus random traffic against an arithmetic reference model.
module tb_alu_pipe;
    localparam int W  = 8;
    localparam int P  = 2;
    localparam int WC = 16;

    logic        clk = 1'b0;
    logic        rst, ce, mode, cin;
    logic [1:0]  inp_valid;
    logic [3:0]  cmd;
    logic [7:0]  opa, opb;
    logic [15:0] res;
    logic        cout, oflow, g, l, e, err, res_valid;

    int checks = 0;
    int errors = 0;

    alu_pipe #(.WIDTH(W), .CMD_WIDTH(4), .PIPE_STAGES(P), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst(rst), .ce(ce), .mode(mode), .cin(cin), .inp_valid(inp_valid),
        .cmd(cmd), .opa(opa), .opb(opb), .res(res), .cout(cout), .oflow(oflow),
        .g(g), .l(l), .e(e), .err(err), .res_valid(res_valid)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [21:0] out; } item_t;
    item_t       sbq[$];
    int          tick = 0;
    logic        exp_valid = 1'b0;
    logic [21:0] exp_out = '0;
    bit          pend = 0, pend_has_a = 0, p_mode = 0, p_cin = 0;
    int          p_a = 0, p_b = 0, p_cmd = 0, waited = 0;

    // Packed as {res[15:0], cout, oflow, g, l, e, err}
    function automatic logic [21:0] ref_alu(int a, int b, int c, int m, int ci);
        int r = 0, s = 0, sa = 0, sb = 0, k = 0;
        bit co = 0, ov = 0, gg = 0, ll = 0, ee = 0, er = 0;
        if (m != 0) begin
            case (c)
                0: begin r = a + b; co = (r > 255); end
                1: begin r = (a - b) & 255; ov = (a < b); end
                2: begin r = a + b + ci; co = (r > 255); end
                3: begin s = a - b - ci; r = s & 255; ov = (s < 0); end
                4: begin r = a + 1; co = (r > 255); end
                5: begin r = (a - 1) & 255; ov = (a == 0); end
                6: begin r = b + 1; co = (r > 255); end
                7: begin r = (b - 1) & 255; ov = (b == 0); end
                8: begin ee = (a == b); gg = (a > b); ll = (a < b); end
                9: r = ((a + 1) * (b + 1)) & 'hFFFF;
                10: r = ((a * 2) * b) & 'hFFFF;
`ifdef ALU_PIPE_SIGNED_EN
                11, 12: begin
                    sa = (a >= 128) ? a - 256 : a;
                    sb = (b >= 128) ? b - 256 : b;
                    s  = (c == 11) ? sa + sb : sa - sb;
                    ov = (s > 127) || (s < -128);
                    r  = s & 255;
                    if (r >= 128) r = r | 'hFF00;
                    if (c == 12) begin gg = (sa > sb); ll = (sa < sb); ee = (sa == sb); end
                end
`endif
                default: er = 1;
            endcase
        end else begin
            k = b & 7;
            case (c)
                0: r = a & b;
                1: r = ~(a & b) & 255;
                2: r = a | b;
                3: r = ~(a | b) & 255;
                4: r = a ^ b;
                5: r = ~(a ^ b) & 255;
                6: r = ~a & 255;
                7: r = ~b & 255;
                8: r = a >> 1;
                9: r = (a << 1) & 255;
                10: r = b >> 1;
                11: r = (b << 1) & 255;
                12: begin r = ((a << k) | (a >> (8 - k))) & 255; er = (b >= 8); end
                13: begin r = ((a >> k) | (a << (8 - k))) & 255; er = (b >= 8); end
                default: er = 1;
            endcase
        end
        return {r[15:0], co, ov, gg, ll, ee, er};
    endfunction

    // 1 = opa only, 2 = opb only, 3 = both
    function automatic int needs(int m, int c);
        if (m != 0) begin
            if (c == 4 || c == 5) return 1;
            if (c == 6 || c == 7) return 2;
        end else begin
            if (c == 6 || c == 8 || c == 9) return 1;
            if (c == 7 || c == 10 || c == 11) return 2;
        end
        return 3;
    endfunction

    task automatic model_edge(int iv, int a, int b, int c, int m, int ci);
        bit          iss = 0;
        logic [21:0] o = '0;
        int          nd;
        if (!pend) begin
            if (iv == 3) begin
                iss = 1; o = ref_alu(a, b, c, m, ci);
            end else if (iv != 0) begin
                nd = needs(m, c);
                if (nd == 3) begin
                    pend = 1; pend_has_a = (iv == 1); waited = 0;
                    p_a = a; p_b = b; p_cmd = c; p_mode = m[0]; p_cin = ci[0];
                end else begin
                    iss = 1; o = ref_alu(a, b, c, m, ci);
                    if (nd != iv) o[0] = 1'b1;
                end
            end
        end else begin
            if ((pend_has_a && iv[1]) || (!pend_has_a && iv[0])) begin
                iss = 1; pend = 0;
                if (pend_has_a) o = ref_alu(p_a, b, p_cmd, int'(p_mode), int'(p_cin));
                else            o = ref_alu(a, p_b, p_cmd, int'(p_mode), int'(p_cin));
            end else if (waited == WC) begin
                iss = 1; pend = 0; o = 22'h1;
            end else begin
                waited++;
            end
        end
        if (iss) sbq.push_back('{tick + P - 1, o});
    endtask

    task automatic chk(input string tag, input logic [21:0] obs, input logic [21:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(bit ce_i, int m, int c, int ci, int iv, int a, int b);
        ce = ce_i; mode = m[0]; cmd = c[3:0]; cin = ci[0];
        inp_valid = iv[1:0]; opa = a[7:0]; opb = b[7:0];
        @(posedge clk);
        if (ce_i) begin
            tick++;
            model_edge(iv, a, b, c, m, ci);
            if (sbq.size() > 0 && sbq[0].due == tick) begin
                exp_valid = 1'b1;
                exp_out   = sbq[0].out;
                void'(sbq.pop_front());
            end else begin
                exp_valid = 1'b0;
            end
        end
        #1;
        chk("res_valid", {21'b0, res_valid}, {21'b0, exp_valid});
        chk("outputs", {res, cout, oflow, g, l, e, err}, exp_out);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        inp_valid = 2'b00;
        #2 rst = 1'b1;
        sbq.delete();
        pend = 0; exp_valid = 1'b0; exp_out = '0;
        #1;
        chk("reset_valid", {21'b0, res_valid}, 22'h0);
        chk("reset_outputs", {res, cout, oflow, g, l, e, err}, 22'h0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; mode = 1'b0; cin = 1'b0; inp_valid = 2'b00;
        cmd = '0; opa = '0; opb = '0;
        @(posedge clk);
        #1;
        chk("init_valid", {21'b0, res_valid}, 22'h0);
        chk("init_outputs", {res, cout, oflow, g, l, e, err}, 22'h0);
        rst = 1'b0;

        // ADD carry out
        step(1, 1, 0, 0, 3, 'hFF, 'h01);
        idle(1);
        chk("add_res", {6'b0, res}, 22'h0100);
        chk("add_cout", {21'b0, cout}, 22'h1);
        idle(1);

        // MUL_INC then SUB back to back
        step(1, 1, 9, 0, 3, 3, 4);
        step(1, 1, 1, 0, 3, 2, 5);
        chk("mul_inc_res", {6'b0, res}, 22'h0014);
        idle(1);
        chk("sub_res", {6'b0, res}, 22'h00FD);
        chk("sub_oflow", {21'b0, oflow}, 22'h1);
        chk("sub_strobe", {21'b0, res_valid}, 22'h1);

        // CMP split beats; second beat carries a different cmd which must be ignored
        step(1, 1, 8, 0, 1, 7, 0);
        idle(5);
        step(1, 0, 4, 0, 2, 0, 9);
        idle(1);
        chk("cmp_l", {21'b0, l}, 22'h1);
        chk("cmp_err", {21'b0, err}, 22'h0);

        // Timeout
        step(1, 1, 0, 0, 1, 'h55, 0);
        for (int i = 0; i < 30 && !res_valid; i++) idle(1);
        chk("timeout_strobe", {21'b0, res_valid}, 22'h1);
        chk("timeout_err_res", {res, err}, 17'h1);

        // Missing operand arrives on the timeout cycle
        step(1, 1, 0, 0, 1, 'h10, 0);
        idle(WC);
        step(1, 1, 0, 0, 2, 0, 'h20);
        idle(1);
        chk("late_win_res", {6'b0, res}, 22'h0030);
        chk("late_win_err", {21'b0, err}, 22'h0);

        // Rotate with out-of-range amount
        step(1, 0, 12, 0, 3, 'h81, 'h11);
        idle(1);
        chk("rol_res", {6'b0, res}, 22'h0003);
        chk("rol_err", {21'b0, err}, 22'h1);

        // Single-operand command with its operand absent
        step(1, 1, 4, 0, 2, 'h33, 'h44);
        idle(2);

        // ce low mid-pipeline and while a strobe is up
        step(1, 1, 0, 0, 3, 'h12, 'h34);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 3, 'hAA, 'hBB);
        idle(1);
        chk("ce_res", {6'b0, res}, 22'h0046);
        step(0, 1, 0, 0, 3, 'h01, 'h01);
        chk("ce_hold_valid", {21'b0, res_valid}, 22'h1);
        idle(2);

        // Reset while in WAIT_B, and with results in flight
        step(1, 1, 0, 0, 1, 'h05, 0);
        idle(3);
        do_reset();
        idle(4);
        step(1, 1, 0, 0, 3, 1, 2);
        do_reset();
        idle(4);

`ifdef ALU_PIPE_SIGNED_EN
        step(1, 1, 11, 0, 3, 'h7F, 'h01);
        idle(1);
        chk("s_add_oflow", {21'b0, oflow}, 22'h1);
        chk("s_add_res", {6'b0, res}, 22'hFF80);
`else
        step(1, 1, 11, 0, 3, 'h7F, 'h01);
        idle(1);
        chk("cmd11_err", {res, cout, oflow, g, l, e, err}, 22'h1);
`endif
        idle(2);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            int iv;
            iv = ($urandom_range(0, 1) != 0) ? 3 : int'($urandom_range(0, 2));
            step($urandom_range(0, 9) != 0, int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 1)), iv, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            if (n == 400) do_reset();
        end
        idle(WC + 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined successor to the team's single-cycle ALU. It accepts operands that may arrive in separate beats (`inp_valid`), pairs them under a bounded wait, and executes arithmetic/logical commands through a configurable-depth result pipeline. It flags every completed operation with `res_valid`. It sits between the operand sequencer and the result scoreboard in the datapath test harness.

## Interface
- `WIDTH`, 8: operand width (≥4, power of two).
- `CMD_WIDTH`, 4: command width.
- `PIPE_STAGES`, 1: issue-to-result latency in cycles (1..4).
- `WAIT_CYCLES`, 16: maximum cycles to wait for a missing operand (2..255).

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ce` in 1: clock enable. When low, the FSM, timer and pipeline are frozen.
- `mode` in 1: 1 = arithmetic, 0 = logical.
- `cin` in 1: carry/borrow-in for ADD_CIN/SUB_CIN.
- `inp_valid` in 2: bit0 = `opa` valid, bit1 = `opb` valid.
- `cmd` in CMD_WIDTH: command.
- `opa`, `opb` in WIDTH: operands.
- `res` out 2*WIDTH: result, zero-extended.
- `cout` out 1: carry out.
- `oflow` out 1: borrow or overflow.
- `g`, `l`, `e` out 1 each: compare flags.
- `err` out 1: error.
- `res_valid` out 1: one-cycle strobe per completed operation.

## Operation
- Arithmetic commands (`mode=1`):
  - 0 ADD, 1 SUB, 2 ADD_CIN, 3 SUB_CIN, 4 INC_A, 5 DEC_A, 6 INC_B, 7 DEC_B, 8 CMP, 9 MUL_INC = (a+1)*(b+1), 10 MUL_SHL = (a<<1)*b.
- Logical commands (`mode=0`):
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT_A, 7 NOT_B, 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B, 12 ROL_A_B, 13 ROR_A_B.
- Operand need:
  - A-only: INC_A, DEC_A, NOT_A, SHR1_A, SHL1_A.
  - B-only: INC_B, DEC_B, NOT_B, SHR1_B, SHL1_B.
  - All others need both operands.
- Width rules:
  - Add results use bits [WIDTH:0], with `cout` = bit WIDTH.
  - SUB/DEC: `oflow` = unsigned borrow; `res` holds the low WIDTH bits of the difference.
  - Multiplies use the full 2*WIDTH result.
  - Logical results are WIDTH bits; the upper half is 0.
- Rotates use the amount `opb[log2(WIDTH)-1:0]`. Any higher `opb` bit set → `err=1`, result still computed.
- CMP sets exactly one of `e`/`g`/`l` (unsigned compare) and `res=0`. For all other commands `g`, `l`, `e` are 0.
- Undefined `cmd`/`mode` combination → `err=1`, all other outputs 0.
- Capture FSM, states IDLE, WAIT_A, WAIT_B:
  - IDLE, `inp_valid=11`: issue.
  - IDLE, beat carrying every operand the command needs: issue.
  - IDLE, two-operand command with `01`: latch `opa`, `cmd`, `mode`, `cin`; go to WAIT_B and clear the timer.
  - IDLE, two-operand command with `10`: same, but latch `opb` and go to WAIT_A.
  - IDLE, single-operand command whose operand is absent (e.g. INC_A with `10`): issue with `err=1`.
  - IDLE, `00`: no action.
  - WAIT_x, beat with the missing operand valid: take that operand only; the latched operand/`cmd`/`mode`/`cin` are kept. Issue and return to IDLE.
  - WAIT_x, timer reaches WAIT_CYCLES: issue with `err=1`, `res=0`, and return to IDLE.
  - The timer increments on each `ce=1` cycle spent in WAIT_x.

## Timing
- Reset: all outputs 0, FSM in IDLE, timer 0, pipeline valid bits cleared.
- Reset asserted mid-operation discards all in-flight and pending operations; no `res_valid` is produced for them.
- Issue cycle N (`ce=1`) → outputs and `res_valid=1` at clock edge N+PIPE_STAGES. Latency is the same for every command.
- Throughput: one issue per cycle when `inp_valid=11`. Back-to-back results occur on consecutive cycles.
- `ce=0`: every register holds, including `res_valid` and the outputs. Consumers sample only when `ce=1`.
- Timeout issue happens on the cycle the timer hits WAIT_CYCLES. If the missing operand arrives on that same cycle, it wins and there is no error.
- Outputs hold their last value between strobes.
- `res_valid` is low on any cycle with no result.

## Configuration
- `ALU_PIPE_SIGNED_EN` defined:
  - Arithmetic cmd 11 = S_ADD and cmd 12 = S_SUB, operating on two's-complement operands.
  - `oflow` = signed overflow; `res` is the WIDTH-bit result sign-extended to 2*WIDTH.
  - `g`/`l`/`e` are also set for S_SUB, using signed comparison.
- `ALU_PIPE_SIGNED_EN` undefined: arithmetic cmd 11/12 are undefined and give `err=1`.

## Test plan
All scenarios use WIDTH=8, PIPE_STAGES=2, WAIT_CYCLES=16.
- ADD `opa=0xFF`, `opb=0x01`, `inp_valid=11` → two cycles later: `res=0x0100`, `cout=1`, `res_valid=1` for one cycle.
- MUL_INC `opa=3`, `opb=4` issued, then SUB `opa=2`, `opb=5` on the next cycle:
  - `res=0x0014`, then `res=0x00FD` with `oflow=1`, on consecutive cycles.
- CMP split beats: `inp_valid=01` with `opa=7`, then 5 idle cycles, then `inp_valid=10` with `opb=9` → `l=1`, `err=0`.
- `inp_valid=01` with ADD, then no further beat for 16 cycles → `err=1`, `res=0`, `res_valid=1`.
- ROL_A_B `opa=0x81`, `opb=0x11` → `res=0x0003`, `err=1`.
- `ce` low for 3 cycles mid-pipeline holds the outputs; reset asserted while in WAIT_B → all outputs 0 and no `res_valid`.
  - With `ALU_PIPE_SIGNED_EN` defined, S_ADD `0x7F+0x01` → `oflow=1`.
